// File: rtl/ipif_ce_master.sv
// Single-beat chip-enable bus initiator: one request in, one CE access to the
// slave, one response out, with a bounded wait for the slave acknowledge.
module ipif_ce_master #(
    parameter int unsigned C_NUM_REG    = 4,
    parameter int unsigned C_SLV_DWIDTH = 32,
    parameter int unsigned C_SEL_WIDTH  = 2,
    parameter int unsigned C_TIMEOUT    = 16
) (
    input  logic                      Bus2IP_Clk,
    input  logic                      Bus2IP_Reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_wr,
    input  logic [C_SEL_WIDTH-1:0]    req_sel,
    input  logic [C_SLV_DWIDTH-1:0]   req_data,
    input  logic [C_SLV_DWIDTH/8-1:0] req_be,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [C_SLV_DWIDTH-1:0]   rsp_data,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic [C_SLV_DWIDTH-1:0]   Bus2IP_Data,
    output logic [C_SLV_DWIDTH/8-1:0] Bus2IP_BE,
    output logic [C_NUM_REG-1:0]      Bus2IP_RdCE,
    output logic [C_NUM_REG-1:0]      Bus2IP_WrCE,
    input  logic [C_SLV_DWIDTH-1:0]   IP2Bus_Data,
    input  logic                      IP2Bus_RdAck,
    input  logic                      IP2Bus_WrAck,
    input  logic                      IP2Bus_Error
);

    localparam int unsigned BEW  = C_SLV_DWIDTH / 8;
    localparam int unsigned CNTW = 8;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                  r_state;
    logic                    r_wr;
    logic [CNTW-1:0]         r_cnt;
    logic [C_NUM_REG-1:0]    w_ce;
    logic                    w_sel_ok;
    logic                    w_ack;

    // Register index i maps to CE bit [C_NUM_REG-1-i] (MSB-first numbering).
    always_comb begin
        w_ce = '0;
        for (int unsigned i = 0; i < C_NUM_REG; i++) begin
            w_ce[C_NUM_REG-1-i] = (32'(req_sel) == i);
        end
    end

    assign w_sel_ok = (32'(req_sel) < C_NUM_REG);
    assign w_ack    = r_wr ? IP2Bus_WrAck : IP2Bus_RdAck;

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            r_state     <= IDLE;
            r_wr        <= 1'b0;
            r_cnt       <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            Bus2IP_Data <= '0;
            Bus2IP_BE   <= '0;
            Bus2IP_RdCE <= '0;
            Bus2IP_WrCE <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        r_wr      <= req_wr;
                        r_cnt     <= '0;
                        if (w_sel_ok) begin
                            r_state     <= ACCESS;
                            Bus2IP_RdCE <= req_wr ? '0 : w_ce;
                            Bus2IP_WrCE <= req_wr ? w_ce : '0;
                            Bus2IP_Data <= req_wr ? req_data : '0;
                            Bus2IP_BE   <= req_be;
                        end else begin
                            // Out-of-range index never touches the bus.
                            r_state     <= RESP;
                            rsp_valid   <= 1'b1;
                            rsp_data    <= '0;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (w_ack) begin
                        r_state     <= RESP;
                        rsp_valid   <= 1'b1;
                        rsp_data    <= r_wr ? '0 : IP2Bus_Data;
                        rsp_err     <= IP2Bus_Error;
                        rsp_timeout <= 1'b0;
                        Bus2IP_RdCE <= '0;
                        Bus2IP_WrCE <= '0;
                        Bus2IP_Data <= '0;
                        Bus2IP_BE   <= BEW'(0);
                    end else if (r_cnt == CNTW'(C_TIMEOUT - 1)) begin
                        r_state     <= RESP;
                        rsp_valid   <= 1'b1;
                        rsp_data    <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        Bus2IP_RdCE <= '0;
                        Bus2IP_WrCE <= '0;
                        Bus2IP_Data <= '0;
                        Bus2IP_BE   <= BEW'(0);
                    end else begin
                        r_cnt <= r_cnt + CNTW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state   <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
